// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit types for the MBR access arbiter:
// FSM states, owners, write-source codes and control-word bit indices.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_RWAIT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_WRITE   = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_EXEC  = 1'b1
  } owner_t;

  localparam int CS_MBR_LD_RAM = 3;
  localparam int CS_MBR_LD_ACC = 11;
  localparam int CS_MBR_LD_MR  = 12;
  localparam int CS_MBR_LD_DR  = 13;

  localparam logic [1:0] SRC_ACC = 2'd0;
  localparam logic [1:0] SRC_MR  = 2'd1;
  localparam logic [1:0] SRC_DR  = 2'd2;
  localparam logic [1:0] SRC_ILL = 2'd3;

  function automatic logic src_illegal(
    input logic       we,
    input logic [1:0] src
  );
    return we && (src == SRC_ILL);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; bit 0 = fetch, bit 1 = execute.
// Ties go to whichever side did not win last; execute is "last" after reset.
module rr_arb2
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  owner_t last_owner;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (1'b1)
        (req == 2'b11):
          gnt = (last_owner == OWN_EXEC) ? 2'b01 : 2'b10;
        (req == 2'b01): gnt = 2'b01;
        (req == 2'b10): gnt = 2'b10;
        default:        gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner <= OWN_EXEC;
    end else if (gnt != 2'b00) begin
      last_owner <= gnt[1] ? OWN_EXEC : OWN_FETCH;
    end
  end

endmodule

// File: rtl/mbr_access_arbiter.sv
// Shares the MAR/MBR/RAM path between fetch and execute, sequencing
// each grant as a RAM read into MBR or an MBR load followed by RAM write.
module mbr_access_arbiter
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_done,
  input  logic              e_req,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic              e_we,
  input  logic [1:0]        e_src,
  output logic              e_done,
  output logic              mar_ld,
  output logic [ADDR_W-1:0] mar_addr,
  output logic              mbr_ld_ram,
  output logic              mbr_ld_acc,
  output logic              mbr_ld_mr,
  output logic              mbr_ld_dr,
  output logic              ram_we,
  output logic              busy,
  output logic              err
);

  localparam logic [1:0] LAT_M1 =
    (RAM_LAT > 0) ? 2'(RAM_LAT - 1) : 2'd0;

  state_t     state;
  state_t     state_nx;
  owner_t     owner_q;
  logic       we_q;
  logic [1:0] src_q;
  logic [1:0] cnt;
  logic [1:0] gnt;
  logic       grant;
  logic       wr_addr;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == ST_IDLE),
    .req   ({e_req, f_req}),
    .gnt   (gnt)
  );

  assign grant = (state == ST_IDLE) && (gnt != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      owner_q  <= OWN_EXEC;
      we_q     <= 1'b0;
      src_q    <= SRC_ACC;
      mar_addr <= '0;
      cnt      <= 2'd0;
      err      <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= (state == ST_RWAIT) ? cnt + 2'd1 : 2'd0;
      if (grant) begin
        owner_q  <= gnt[1] ? OWN_EXEC : OWN_FETCH;
        we_q     <= gnt[1] & e_we;
        src_q    <= e_src;
        mar_addr <= gnt[1] ? e_addr : f_addr;
        if (gnt[1] && src_illegal(e_we, e_src)) begin
          err <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (grant) state_nx = ST_ADDR;
      end
      ST_ADDR: begin
        if (we_q)              state_nx = ST_WRITE;
        else if (RAM_LAT == 0) state_nx = ST_CAPTURE;
        else                   state_nx = ST_RWAIT;
      end
      ST_RWAIT: begin
        if (cnt == LAT_M1) state_nx = ST_CAPTURE;
      end
      ST_CAPTURE: state_nx = ST_DONE;
      ST_WRITE:   state_nx = ST_DONE;
      ST_DONE:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Write data reaches MBR in the same cycle MAR loads.
  assign wr_addr    = (state == ST_ADDR) && we_q;
  assign mar_ld     = (state == ST_ADDR);
  assign mbr_ld_acc = wr_addr && (src_q == SRC_ACC);
  assign mbr_ld_mr  = wr_addr && (src_q == SRC_MR);
  assign mbr_ld_dr  = wr_addr && (src_q == SRC_DR);
  assign mbr_ld_ram = (state == ST_CAPTURE);
  assign ram_we     = (state == ST_WRITE);
  assign busy       = (state != ST_IDLE);
  assign f_done     = (state == ST_DONE) && (owner_q == OWN_FETCH);
  assign e_done     = (state == ST_DONE) && (owner_q == OWN_EXEC);

endmodule

// File: tb/tb_mbr_access_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run
// compared against a transaction-timeline model (RAM_LAT=1 instance).
module tb_mbr_access_arbiter;

  localparam int AW  = 8;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          f_req = 1'b0;
  logic          e_req = 1'b0;
  logic          e_we = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic [AW-1:0] e_addr = '0;
  logic [1:0]    e_src = '0;

  logic [2:0]    o_f_done, o_e_done, o_mar_ld, o_ram;
  logic [2:0]    o_acc, o_mr, o_dr, o_we, o_busy, o_err;
  logic [AW-1:0] o_addr [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Instances 0,1,2 use RAM_LAT 0,1,3; instance 1 is the main DUT.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    mbr_access_arbiter #(.ADDR_W(AW), .RAM_LAT(L)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .f_req      (f_req),
      .f_addr     (f_addr),
      .f_done     (o_f_done[g]),
      .e_req      (e_req),
      .e_addr     (e_addr),
      .e_we       (e_we),
      .e_src      (e_src),
      .e_done     (o_e_done[g]),
      .mar_ld     (o_mar_ld[g]),
      .mar_addr   (o_addr[g]),
      .mbr_ld_ram (o_ram[g]),
      .mbr_ld_acc (o_acc[g]),
      .mbr_ld_mr  (o_mr[g]),
      .mbr_ld_dr  (o_dr[g]),
      .ram_we     (o_we[g]),
      .busy       (o_busy[g]),
      .err        (o_err[g])
    );
  end

  logic [16:0] dut_v;
  assign dut_v = {o_mar_ld[1], o_addr[1], o_ram[1], o_acc[1],
                  o_mr[1], o_dr[1], o_we[1], o_f_done[1],
                  o_e_done[1], o_busy[1], o_err[1]};

  // Reference model: a transaction is "active" for offsets 1..len
  // after grant; every strobe is a fixed offset into that window.
  logic          m_act, m_own, m_we, m_last, m_err;
  logic [1:0]    m_src;
  logic [AW-1:0] m_addr;
  int            m_k;

  function automatic int m_len(input logic we);
    return we ? 3 : 3 + LAT;
  endfunction

  function automatic logic m_pick(input logic f, e, last);
    if (f && e) return !last;
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0; m_k <= 0; m_own <= 1'b0; m_we <= 1'b0;
      m_src <= 2'd0; m_addr <= '0; m_last <= 1'b1; m_err <= 1'b0;
    end else if (!m_act) begin
      if (f_req || e_req) begin
        m_act  <= 1'b1;
        m_k    <= 1;
        m_own  <= m_pick(f_req, e_req, m_last);
        m_last <= m_pick(f_req, e_req, m_last);
        m_we   <= m_pick(f_req, e_req, m_last) && e_we;
        m_src  <= e_src;
        m_addr <= m_pick(f_req, e_req, m_last) ? e_addr : f_addr;
        if (m_pick(f_req, e_req, m_last) && e_we && e_src == 2'd3)
          m_err <= 1'b1;
      end
    end else if (m_k == m_len(m_we)) begin
      m_act <= 1'b0;
      m_k   <= 0;
    end else begin
      m_k <= m_k + 1;
    end
  end

  logic [16:0] exp_v;
  logic        x_wr1, x_dn;
  always_comb begin
    x_wr1 = m_act && m_we && (m_k == 1);
    x_dn  = m_act && (m_k == m_len(m_we));
    exp_v = {m_act && (m_k == 1), m_addr,
             m_act && !m_we && (m_k == 2 + LAT),
             x_wr1 && (m_src == 2'd0), x_wr1 && (m_src == 2'd1),
             x_wr1 && (m_src == 2'd2), m_act && m_we && (m_k == 2),
             x_dn && !m_own, x_dn && m_own, m_act, m_err};
  end

  // One clock; also enforces the strobe invariants on all instances.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if ($countones({o_acc[i], o_mr[i], o_dr[i], o_ram[i]}) > 1 ||
          (o_we[i] && o_ram[i])) begin
        n_fail++;
        $display("FAIL invariant dut%0d: mbr_ld=%b ram_we=%b, need <=1 strobe, no ram_we with ld_ram",
                 i, {o_ram[i], o_acc[i], o_mr[i], o_dr[i]}, o_we[i]);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    f_req = 1'b0; e_req = 1'b0; e_we = 1'b0; e_src = 2'd0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_mar_ld, o_ram, o_acc, o_mr, o_dr, o_we, o_f_done,
         o_e_done, o_busy, o_err} !== 30'd0 || dut_v !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, need 0", dut_v);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    n_tests++;
    if (dut_v !== 17'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h, need 0", dut_v);
    end
  endtask

  task automatic test_fetch();
    f_addr = 8'h12;
    f_req  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      n_tests++;
      if (o_mar_ld[1] !== (k == 1) || (k == 1 && o_addr[1] !== 8'h12)) begin
        n_fail++;
        $display("FAIL fetch_mar k=%0d: mar_ld=%b addr=%h, need %b/12",
                 k, o_mar_ld[1], o_addr[1], k == 1);
      end
      n_tests++;
      if (o_ram[1] !== (k == 3) || o_f_done[1] !== (k == 4) ||
          o_e_done[1] !== 1'b0 || o_busy[1] !== (k <= 4)) begin
        n_fail++;
        $display("FAIL fetch_seq k=%0d: ld_ram=%b f_done=%b e_done=%b busy=%b",
                 k, o_ram[1], o_f_done[1], o_e_done[1], o_busy[1]);
      end
      if (k == 4) f_req = 1'b0;
    end
  endtask

  task automatic test_write();
    e_addr = 8'h40; e_we = 1'b1; e_src = 2'd2; e_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      n_tests++;
      if (o_mar_ld[1] !== (k == 1) || o_dr[1] !== (k == 1) ||
          (k == 1 && o_addr[1] !== 8'h40) ||
          o_acc[1] !== 1'b0 || o_mr[1] !== 1'b0 || o_ram[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL write_addr k=%0d: mar_ld=%b dr=%b acc=%b mr=%b ram=%b addr=%h",
                 k, o_mar_ld[1], o_dr[1], o_acc[1], o_mr[1], o_ram[1], o_addr[1]);
      end
      n_tests++;
      if (o_we[1] !== (k == 2) || o_e_done[1] !== (k == 3) ||
          o_f_done[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL write_seq k=%0d: ram_we=%b e_done=%b f_done=%b",
                 k, o_we[1], o_e_done[1], o_f_done[1]);
      end
      if (k == 3) e_req = 1'b0;
    end
    e_we = 1'b0;
  endtask

  task automatic test_round_robin();
    int t;
    do_reset();
    f_addr = 8'h11; e_addr = 8'h22;
    f_req = 1'b1; e_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      do begin cyc(); t++; end while (!o_mar_ld[1] && t < 12);
      n_tests++;
      if (!o_mar_ld[1] || o_addr[1] !== ((i % 2) ? 8'h22 : 8'h11)) begin
        n_fail++;
        $display("FAIL rr_grant %0d: mar_ld=%b addr=%h, need 1/%h",
                 i, o_mar_ld[1], o_addr[1], (i % 2) ? 8'h22 : 8'h11);
      end
      t = 0;
      do begin cyc(); t++; end
      while (!(o_f_done[1] || o_e_done[1]) && t < 12);
      n_tests++;
      if (o_f_done[1] !== (i % 2 == 0) || o_e_done[1] !== (i % 2 == 1)) begin
        n_fail++;
        $display("FAIL rr_done %0d: f_done=%b e_done=%b, need %b/%b",
                 i, o_f_done[1], o_e_done[1], i % 2 == 0, i % 2 == 1);
      end
    end
    f_req = 1'b0; e_req = 1'b0;
    cyc();
  endtask

  task automatic test_illegal_src();
    do_reset();
    e_addr = 8'h5A; e_we = 1'b1; e_src = 2'd3; e_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      n_tests++;
      if ({o_ram[1], o_acc[1], o_mr[1], o_dr[1]} !== 4'd0 ||
          o_mar_ld[1] !== (k == 1) || o_we[1] !== (k == 2) ||
          o_e_done[1] !== (k == 3) || o_err[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL illegal k=%0d: ld=%b mar=%b we=%b e_done=%b err=%b",
                 k, {o_ram[1], o_acc[1], o_mr[1], o_dr[1]},
                 o_mar_ld[1], o_we[1], o_e_done[1], o_err[1]);
      end
      if (k == 3) e_req = 1'b0;
    end
    e_addr = 8'h33; e_src = 2'd0; e_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      n_tests++;
      if (o_acc[1] !== (k == 1) || o_mr[1] !== 1'b0 || o_dr[1] !== 1'b0 ||
          o_e_done[1] !== (k == 3) || o_err[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL err_sticky k=%0d: acc=%b mr=%b dr=%b e_done=%b err=%b",
                 k, o_acc[1], o_mr[1], o_dr[1], o_e_done[1], o_err[1]);
      end
      if (k == 3) e_req = 1'b0;
    end
    e_we = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    f_addr = 8'h77; f_req = 1'b1;
    cyc();
    cyc();
    n_tests++;
    if (o_busy[1] !== 1'b1 || o_mar_ld[1] !== 1'b0 || o_ram[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rwait: busy=%b mar_ld=%b ld_ram=%b, need 1/0/0",
               o_busy[1], o_mar_ld[1], o_ram[1]);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (dut_v !== 17'd0) begin
      n_fail++;
      $display("FAIL mid_reset_out: got %h, need 0", dut_v);
    end
    f_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_tests++;
      if (o_f_done[1] !== 1'b0 || o_busy[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_hold: f_done=%b busy=%b, need 0",
                 o_f_done[1], o_busy[1]);
      end
    end
    rst_n = 1'b1;
    f_addr = 8'h78; f_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      n_tests++;
      if (o_f_done[1] !== (k == 4) || (k == 1 && o_addr[1] !== 8'h78)) begin
        n_fail++;
        $display("FAIL after_reset k=%0d: f_done=%b addr=%h", k,
                 o_f_done[1], o_addr[1]);
      end
      if (k == 4) f_req = 1'b0;
    end
  endtask

  task automatic test_latency();
    int dl [3];
    dl = '{3, 4, 6};
    do_reset();
    f_addr = 8'h3C; f_req = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (o_mar_ld[i] !== 1'b1 || o_addr[i] !== 8'h3C ||
          o_err[i] !== 1'b0 || o_busy[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL lat_grant dut%0d: mar_ld=%b addr=%h err=%b busy=%b",
                 i, o_mar_ld[i], o_addr[i], o_err[i], o_busy[i]);
      end
    end
    f_req = 1'b0;
    for (int k = 2; k <= 7; k++) begin
      cyc();
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (o_f_done[i] !== (k == dl[i]) || o_e_done[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL lat_done dut%0d k=%0d: f_done=%b e_done=%b, need %b/0",
                   i, k, o_f_done[i], o_e_done[i], k == dl[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst_n  = ($urandom_range(0, 99) != 0);
      f_req  = ($urandom_range(0, 3) != 0);
      e_req  = ($urandom_range(0, 3) != 0);
      f_addr = AW'($urandom);
      e_addr = AW'($urandom);
      e_we   = 1'($urandom);
      e_src  = 2'($urandom);
      cyc();
      n_tests++;
      if (dut_v !== exp_v) begin
        n_fail++;
        $display("FAIL random c=%0d: got %h, need %h", c, dut_v, exp_v);
      end
    end
    rst_n = 1'b1;
    f_req = 1'b0; e_req = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch();
    test_write();
    test_round_robin();
    test_illegal_src();
    test_reset_mid();
    test_latency();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
